instruction_memory: RTL and testbench
=====================================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
- REQ-001: Parameter WORD_SIZE SHALL default to 32; it is the instruction and PC width in bits.
- REQ-002: Parameter DEPTH SHALL default to 256; it is the number of words and SHALL be a power of two.
- REQ-003: Port clk SHALL be a 1-bit input; it is the single clock, and all state updates occur on its rising edge.
- REQ-004: Port rst SHALL be a 1-bit input; the block has one clock, and rst is a synchronous, active-low reset.
- REQ-005: Port PC SHALL be a WORD_SIZE-bit input carrying the word index of the instruction to fetch.
- REQ-006: Port Instr SHALL be a WORD_SIZE-bit registered output carrying the fetched instruction word.
- REQ-007: Port addr_err SHALL be a 1-bit registered output that is high when the sampled PC was out of range.

Function
- REQ-008: PC SHALL be a word index, not a byte address: PC=0 selects word 0 and PC=1 selects word 1.
- REQ-009: Read latency SHALL be one cycle: at each rising edge with rst high, Instr <= mem[PC].
- REQ-010: Instr SHALL hold its value between edges; there SHALL be no combinational path from PC to Instr.
- REQ-011: If PC >= DEPTH at a rising edge with rst high, then Instr <= 0 and addr_err <= 1.
- REQ-012: If PC < DEPTH at a rising edge with rst high, then addr_err <= 0.
- REQ-013: The boot image SHALL set word 0 = 32'h00110233 (add x4,x2,x1).
- REQ-014: The boot image SHALL set word 1 = 32'h00310233 (add x4,x2,x3).
- REQ-015: The boot image SHALL set every other word to 32'h00000013 (NOP).
- REQ-016: Only the low log2(DEPTH) bits of PC SHALL index memory; the upper bits SHALL be used only for the range check.

Reset
- REQ-017: At a rising edge with rst low, Instr <= 0 and addr_err <= 0, regardless of PC.
- REQ-018: At a rising edge with rst low, all memory words SHALL be reloaded with the boot image.
- REQ-019: If reset is asserted mid-operation, the next edge SHALL discard the pending fetch.
- REQ-020: The first edge after rst returns high SHALL perform a normal fetch.
- REQ-021: Before the first reset edge, output values SHALL be unspecified.

Configuration
- REQ-022: With macro IMEM_WRITE_PORT_EN defined, the module SHALL add input we (1 bit), input waddr (WORD_SIZE bits) and input wdata (WORD_SIZE bits).
- REQ-023: With IMEM_WRITE_PORT_EN defined, at a rising edge with rst high, we high and waddr < DEPTH, then mem[waddr] <= wdata.
- REQ-024: With IMEM_WRITE_PORT_EN defined, writes with waddr >= DEPTH SHALL be ignored.
- REQ-025: With IMEM_WRITE_PORT_EN defined, writes while rst is low SHALL be ignored.
- REQ-026: With IMEM_WRITE_PORT_EN defined, a read and a write to the same index on the same edge SHALL return wdata on Instr (write-first).
- REQ-027: Without IMEM_WRITE_PORT_EN, the we, waddr and wdata ports SHALL be absent and the contents after reset SHALL be read-only.

Verification
- REQ-028: Scenario: rst=0 for one edge, then rst=1 with PC=0 for one edge -> Instr=32'h00110233 and addr_err=0.
- REQ-029: Scenario: PC=1 at the next edge -> Instr=32'h00310233; Instr is unchanged before that edge.
- REQ-030: Scenario: PC=5 -> Instr=32'h00000013; then PC=256 -> Instr=0 and addr_err=1; then PC=0 -> addr_err=0.
- REQ-031: Scenario: rst=0 with PC=1 -> Instr=0 after the edge; after rst=1, the next edge gives Instr=32'h00310233.
- REQ-032: Scenario (IMEM_WRITE_PORT_EN defined): we=1, waddr=1, wdata=32'hDEADBEEF with PC=1 -> Instr=32'hDEADBEEF on the same edge.
- REQ-033: Scenario (IMEM_WRITE_PORT_EN defined): after the write, pulse reset, then PC=1 -> Instr=32'h00310233.

Source files
------------

// File: rtl/instruction_memory.sv
// Word-indexed instruction ROM/RAM with one-cycle registered read, range-checked PC and boot image reload on reset.
// Optional write port enabled by defining IMEM_WRITE_PORT_EN.
module instruction_memory #(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] PC,
`ifdef IMEM_WRITE_PORT_EN
    input  logic                 we,
    input  logic [WORD_SIZE-1:0] waddr,
    input  logic [WORD_SIZE-1:0] wdata,
`endif
    output logic [WORD_SIZE-1:0] Instr,
    output logic                 addr_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Boot image: two adds at the start, NOP everywhere else.
    function automatic logic [WORD_SIZE-1:0] boot_word(input int idx);
        logic [WORD_SIZE-1:0] w;
        case (idx)
            0:       w = WORD_SIZE'(32'h0011_0233);
            1:       w = WORD_SIZE'(32'h0031_0233);
            default: w = WORD_SIZE'(32'h0000_0013);
        endcase
        return w;
    endfunction

    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [WORD_SIZE-1:0] r_instr_p1;
    logic                 r_addr_err_p1;

    logic [AW-1:0]        w_pc_idx;
    logic                 w_pc_oob;
    logic [WORD_SIZE-1:0] w_rd_data;

    // Low bits index the array; any set upper bit means PC is out of range.
    assign w_pc_idx = PC[AW-1:0];
    assign w_pc_oob = |(PC >> AW);

`ifdef IMEM_WRITE_PORT_EN
    logic          w_wr_en;
    logic [AW-1:0] w_wr_idx;

    assign w_wr_en   = we && !(|(waddr >> AW));
    assign w_wr_idx  = waddr[AW-1:0];
    assign w_rd_data = (w_wr_en && (w_wr_idx == w_pc_idx)) ? wdata : r_mem[w_pc_idx];
`else
    assign w_rd_data = r_mem[w_pc_idx];
`endif

    // Stage p0 -> p1: fetch register and memory update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= boot_word(i);
            end
            r_instr_p1    <= '0;
            r_addr_err_p1 <= 1'b0;
        end else begin
            if (w_pc_oob) begin
                r_instr_p1    <= '0;
                r_addr_err_p1 <= 1'b1;
            end else begin
                r_instr_p1    <= w_rd_data;
                r_addr_err_p1 <= 1'b0;
            end
`ifdef IMEM_WRITE_PORT_EN
            if (w_wr_en) begin
                r_mem[w_wr_idx] <= wdata;
            end
`endif
        end
    end

    assign Instr    = r_instr_p1;
    assign addr_err = r_addr_err_p1;

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed scenarios plus randomized fetches against an array model.
module tb_instruction_memory;

    localparam int WS = 32;
    localparam int D  = 256;
    localparam logic [31:0] ADD1 = 32'h0011_0233;
    localparam logic [31:0] ADD2 = 32'h0031_0233;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic [WS-1:0] PC;
    logic [WS-1:0] Instr;
    logic          addr_err;
`ifdef IMEM_WRITE_PORT_EN
    logic          we;
    logic [WS-1:0] waddr;
    logic [WS-1:0] wdata;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [WS-1:0] m_mem [D];
    logic [WS-1:0] m_instr;
    logic          m_err;

    instruction_memory #(.WORD_SIZE(WS), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .PC       (PC),
`ifdef IMEM_WRITE_PORT_EN
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
`endif
        .Instr    (Instr),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    // Reference behaviour of one rising edge, computed from current inputs.
    task automatic model_edge();
        logic          m_we;
        logic [WS-1:0] m_wa;
        logic [WS-1:0] m_wd;
`ifdef IMEM_WRITE_PORT_EN
        m_we = we; m_wa = waddr; m_wd = wdata;
`else
        m_we = 1'b0; m_wa = '0; m_wd = '0;
`endif
        if (!rst) begin
            for (int i = 0; i < D; i++) m_mem[i] = (i == 0) ? ADD1 : (i == 1) ? ADD2 : NOP;
            m_instr = '0;
            m_err   = 1'b0;
        end else begin
            if (PC >= D) begin
                m_instr = '0;
                m_err   = 1'b1;
            end else begin
                m_instr = (m_we && m_wa < D && m_wa == PC) ? m_wd : m_mem[PC];
                m_err   = 1'b0;
            end
            if (m_we && m_wa < D) m_mem[m_wa] = m_wd;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        PC  = $urandom();
        cycle();
        n_tests++;
        if (Instr !== '0) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", Instr, 32'h0); end
        n_tests++;
        if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected %b", addr_err, 1'b0); end
    endtask

    task automatic test_boot_scenario();
        rst = 1'b1;
        PC  = 0;
        cycle();
        n_tests++;
        if (Instr !== ADD1) begin n_fail++; $display("FAIL boot_w0: got %h expected %h", Instr, ADD1); end
        n_tests++;
        if (addr_err !== 1'b0) begin n_fail++; $display("FAIL boot_w0_err: got %b expected %b", addr_err, 1'b0); end
        PC = 1;
        #2;
        n_tests++;
        if (Instr !== ADD1) begin n_fail++; $display("FAIL hold_before_edge: got %h expected %h", Instr, ADD1); end
        cycle();
        n_tests++;
        if (Instr !== ADD2) begin n_fail++; $display("FAIL boot_w1: got %h expected %h", Instr, ADD2); end
        PC = 5;
        cycle();
        n_tests++;
        if (Instr !== NOP) begin n_fail++; $display("FAIL boot_w5: got %h expected %h", Instr, NOP); end
        PC = 256;
        cycle();
        n_tests++;
        if (Instr !== '0 || addr_err !== 1'b1) begin
            n_fail++; $display("FAIL oob_256: got %h/%b expected %h/%b", Instr, addr_err, 32'h0, 1'b1);
        end
        PC = 0;
        cycle();
        n_tests++;
        if (addr_err !== 1'b0 || Instr !== ADD1) begin
            n_fail++; $display("FAIL back_in_range: got %h/%b expected %h/%b", Instr, addr_err, ADD1, 1'b0);
        end
    endtask

    task automatic test_upper_bits();
        PC = D + 1;
        cycle();
        n_tests++;
        if (Instr !== '0 || addr_err !== 1'b1) begin
            n_fail++; $display("FAIL alias_257: got %h/%b expected %h/%b", Instr, addr_err, 32'h0, 1'b1);
        end
        PC = 32'h8000_0001;
        cycle();
        n_tests++;
        if (Instr !== '0 || addr_err !== 1'b1) begin
            n_fail++; $display("FAIL msb_set: got %h/%b expected %h/%b", Instr, addr_err, 32'h0, 1'b1);
        end
        PC = D - 1;
        cycle();
        n_tests++;
        if (Instr !== NOP || addr_err !== 1'b0) begin
            n_fail++; $display("FAIL last_word: got %h/%b expected %h/%b", Instr, addr_err, NOP, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b0;
        PC  = 1;
        cycle();
        n_tests++;
        if (Instr !== '0) begin n_fail++; $display("FAIL mid_reset_discard: got %h expected %h", Instr, 32'h0); end
        rst = 1'b1;
        cycle();
        n_tests++;
        if (Instr !== ADD2) begin n_fail++; $display("FAIL first_after_reset: got %h expected %h", Instr, ADD2); end
    endtask

    task automatic test_random_reads();
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0:       PC = $urandom_range(0, D - 1);
                1:       PC = $urandom();
                2:       PC = $urandom_range(0, 3);
                default: PC = $urandom_range(D - 2, D + 1);
            endcase
            rst = ($urandom_range(0, 19) != 0);
`ifdef IMEM_WRITE_PORT_EN
            we    = ($urandom_range(0, 2) == 0);
            waddr = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, D - 1);
            wdata = $urandom();
`endif
            cycle();
            n_tests++;
            if (Instr !== m_instr || addr_err !== m_err) begin
                n_fail++;
                $display("FAIL random_read[%0d] pc=%h: got %h/%b expected %h/%b", i, PC, Instr, addr_err, m_instr, m_err);
            end
        end
        rst = 1'b1;
`ifdef IMEM_WRITE_PORT_EN
        we = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            PC = (i % 3 == 0) ? 0 : (i % 3 == 1) ? 1 : D + i;
            cycle();
            n_tests++;
            if (Instr !== m_instr || addr_err !== m_err) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h/%b expected %h/%b", i, Instr, addr_err, m_instr, m_err);
            end
        end
    endtask

`ifdef IMEM_WRITE_PORT_EN
    task automatic test_writes();
        rst = 1'b1;
        we = 1'b1; waddr = 1; wdata = 32'hDEAD_BEEF; PC = 1;
        cycle();
        n_tests++;
        if (Instr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_first: got %h expected %h", Instr, 32'hDEAD_BEEF); end
        we = 1'b0;
        cycle();
        n_tests++;
        if (Instr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_persist: got %h expected %h", Instr, 32'hDEAD_BEEF); end
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        n_tests++;
        if (Instr !== ADD2) begin n_fail++; $display("FAIL reload_after_write: got %h expected %h", Instr, ADD2); end
        we = 1'b1; waddr = D + 3; wdata = 32'h1234_5678;
        cycle();
        we = 1'b0; PC = 3;
        cycle();
        n_tests++;
        if (Instr !== NOP) begin n_fail++; $display("FAIL oob_write_ignored: got %h expected %h", Instr, NOP); end
        rst = 1'b0; we = 1'b1; waddr = 2; wdata = 32'hCAFE_F00D;
        cycle();
        rst = 1'b1; we = 1'b0; PC = 2;
        cycle();
        n_tests++;
        if (Instr !== NOP) begin n_fail++; $display("FAIL reset_write_ignored: got %h expected %h", Instr, NOP); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        PC  = '0;
`ifdef IMEM_WRITE_PORT_EN
        we = 1'b0; waddr = '0; wdata = '0;
`endif
        test_reset();
        test_boot_scenario();
        test_upper_bits();
        test_reset_mid();
`ifdef IMEM_WRITE_PORT_EN
        test_writes();
`endif
        test_random_reads();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
